// File: rtl/tetris_host.sv
`default_nettype none
// ============================================================================
// Module   : tetris_host
// Brief    : Placement-request initiator. Owns a DEPTH x 10 board, drops pieces
//            by gravity and clears full rows.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_host #(
    parameter int DEPTH        = 8,
    parameter int RESP_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        piece_valid,
    input  logic [3:0]  piece_type,
    output logic        piece_ready,
    output logic        req_to_client,
    output logic [3:0]  cur_block,
    output logic [9:0]  row1_info,
    output logic [9:0]  row2_info,
    input  logic        resp_from_client,
    input  logic [3:0]  opt_col,
    input  logic [1:0]  opt_rotation,
    output logic        game_over,
    output logic [15:0] lines_total,
    output logic [15:0] pieces_placed,
    output logic [7:0]  timeout_cnt,
    output logic        bad_resp
);

    localparam int c_RW = $clog2(DEPTH + 1);
    localparam int c_TW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [c_RW-1:0] c_DEPTH_M1 = c_RW'(DEPTH - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_DROP  = 3'd2,
        S_LAND  = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t                 r_state;
    logic                   r_piece_ready;
    logic                   r_req;
    logic [3:0]             r_cur_block;
    logic [DEPTH-1:0][9:0]  r_board;
    logic                   r_game_over;
    logic [15:0]            r_lines;
    logic [15:0]            r_pieces;
    logic [7:0]             r_tmo_cnt;
    logic                   r_bad_resp;
    logic [c_TW-1:0]        r_tmo;
    logic [c_RW-1:0]        r_row;
    logic [c_RW-1:0]        r_h;
    logic [9:0]             r_mask;
    logic                   r_first;
    logic [c_RW-1:0]        r_j;

    // Shape decode for the answer being latched; a timeout behaves as col 0 rot 0.
    logic [3:0]      w_col_req;
    logic [1:0]      w_rot;
    logic [3:0]      w_w;
    logic [c_RW-1:0] w_h;
    logic            w_clamp;
    logic [3:0]      w_col;
    logic [9:0]      w_mask_base;
    logic [9:0]      w_mask;

    assign w_col_req = resp_from_client ? opt_col : 4'd0;
    assign w_rot     = resp_from_client ? opt_rotation : 2'b00;

    always_comb begin
        w_w = 4'd2;
        w_h = c_RW'(2);
        if (r_cur_block == 4'd0) begin
            if (w_rot[0]) begin
                w_w = 4'd1;
                w_h = c_RW'(4);
            end else begin
                w_w = 4'd4;
                w_h = c_RW'(1);
            end
        end
    end

    assign w_clamp = ({1'b0, w_col_req} + {1'b0, w_w}) > 5'd10;
    assign w_col   = w_clamp ? (4'd10 - w_w) : w_col_req;

    always_comb begin
        case (w_w)
            4'd1:    w_mask_base = 10'b1000000000;
            4'd2:    w_mask_base = 10'b1100000000;
            default: w_mask_base = 10'b1111000000;
        endcase
    end

    assign w_mask = w_mask_base >> w_col;

    // Per-row occupancy, collision, full-row and shift terms.
    logic [c_RW-1:0]       w_row_top;
    logic [DEPTH-1:0]      w_in_cur;
    logic [DEPTH-1:0]      w_hit_cur;
    logic [DEPTH-1:0]      w_hit_below;
    logic [DEPTH-1:0]      w_full;
    logic [DEPTH-1:0]      w_at_j;
    logic [DEPTH-1:0][9:0] w_land_board;
    logic [DEPTH-1:0][9:0] w_shift_board;

    assign w_row_top = r_row + r_h;

    for (genvar k = 0; k < DEPTH; k++) begin : g_row
        localparam logic [c_RW-1:0] c_K  = c_RW'(k);
        localparam logic [c_RW-1:0] c_K1 = c_RW'(k + 1);

        assign w_in_cur[k]     = (c_K >= r_row) && (c_K < w_row_top);
        assign w_hit_cur[k]    = w_in_cur[k] && (|(r_board[k] & r_mask));
        assign w_hit_below[k]  = (c_K1 >= r_row) && (c_K1 < w_row_top) && (|(r_board[k] & r_mask));
        assign w_full[k]       = &r_board[k];
        assign w_at_j[k]       = (r_j == c_K);
        assign w_land_board[k] = w_in_cur[k] ? (r_board[k] | r_mask) : r_board[k];

        if (k == DEPTH - 1) begin : g_top
            assign w_shift_board[k] = (r_j <= c_K) ? 10'd0 : r_board[k];
        end else begin : g_mid
            assign w_shift_board[k] = (r_j <= c_K) ? r_board[k+1] : r_board[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_piece_ready <= 1'b0;
            r_req         <= 1'b0;
            r_cur_block   <= 4'd0;
            r_board       <= '0;
            r_game_over   <= 1'b0;
            r_lines       <= 16'd0;
            r_pieces      <= 16'd0;
            r_tmo_cnt     <= 8'd0;
            r_bad_resp    <= 1'b0;
            r_tmo         <= '0;
            r_row         <= '0;
            r_h           <= '0;
            r_mask        <= 10'd0;
            r_first       <= 1'b0;
            r_j           <= '0;
        end else begin
            r_piece_ready <= 1'b0;
            r_bad_resp    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (piece_valid && r_piece_ready) begin
                        r_cur_block <= piece_type;
                        r_req       <= 1'b1;
                        r_tmo       <= '0;
                        r_state     <= S_REQ;
                    end else begin
                        r_piece_ready <= !resp_from_client;
                    end
                end
                S_REQ: begin
                    // A response on the final timeout edge takes priority.
                    if (resp_from_client || (r_tmo == c_TMO_LAST)) begin
                        r_req      <= 1'b0;
                        r_row      <= c_RW'(DEPTH) - w_h;
                        r_h        <= w_h;
                        r_mask     <= w_mask;
                        r_first    <= 1'b1;
                        r_bad_resp <= w_clamp;
                        if (!resp_from_client && (r_tmo_cnt != 8'hFF)) begin
                            r_tmo_cnt <= r_tmo_cnt + 8'd1;
                        end
                        r_state    <= S_DROP;
                    end else begin
                        r_tmo <= r_tmo + c_TW'(1);
                    end
                end
                S_DROP: begin
                    r_first <= 1'b0;
                    if (r_first && (|w_hit_cur)) begin
                        r_game_over <= 1'b1;
                        r_state     <= S_OVER;
                    end else if ((r_row != '0) && !(|w_hit_below)) begin
                        r_row <= r_row - c_RW'(1);
                    end else begin
                        r_state <= S_LAND;
                    end
                end
                S_LAND: begin
                    r_board  <= w_land_board;
                    r_pieces <= r_pieces + 16'd1;
                    r_j      <= '0;
                    r_state  <= S_CLEAR;
                end
                S_CLEAR: begin
                    if (|(w_full & w_at_j)) begin
                        r_board <= w_shift_board;
                        if (r_lines != 16'hFFFF) begin
                            r_lines <= r_lines + 16'd1;
                        end
                    end else if (r_j == c_DEPTH_M1) begin
                        r_state       <= S_IDLE;
                        r_piece_ready <= !resp_from_client;
                    end else begin
                        r_j <= r_j + c_RW'(1);
                    end
                end
                S_OVER: begin
                    r_state <= S_OVER;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign piece_ready   = r_piece_ready;
    assign req_to_client = r_req;
    assign cur_block     = r_cur_block;
    assign row1_info     = r_board[0];
    assign row2_info     = r_board[1];
    assign game_over     = r_game_over;
    assign lines_total   = r_lines;
    assign pieces_placed = r_pieces;
    assign timeout_cnt   = r_tmo_cnt;
    assign bad_resp      = r_bad_resp;

endmodule
`default_nettype wire

// File: tb/tb_tetris_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_host
// Brief    : Directed bench for tetris_host (DEPTH 8 and DEPTH 4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_host;

    logic       clk = 1'b0;
    logic       rst8, rst4, sel4;
    logic       piece_valid, resp;
    logic [3:0] piece_type, opt_col;
    logic [1:0] opt_rot;

    logic        ready8, req8, go8, bad8, ready4, req4, go4, bad4;
    logic [3:0]  cur8, cur4;
    logic [9:0]  r1_8, r2_8, r1_4, r2_4;
    logic [15:0] lines8, pieces8, lines4, pieces4;
    logic [7:0]  tmo8, tmo4;

    int total = 0;
    int bad   = 0;
    int n_req = 0;
    int n_badresp = 0;

    always #5 clk = ~clk;

    tetris_host #(.DEPTH(8), .RESP_TIMEOUT(15)) u_dut8 (
        .clk(clk), .reset(rst8), .piece_valid(piece_valid), .piece_type(piece_type),
        .piece_ready(ready8), .req_to_client(req8), .cur_block(cur8),
        .row1_info(r1_8), .row2_info(r2_8), .resp_from_client(resp),
        .opt_col(opt_col), .opt_rotation(opt_rot), .game_over(go8),
        .lines_total(lines8), .pieces_placed(pieces8), .timeout_cnt(tmo8), .bad_resp(bad8)
    );

    tetris_host #(.DEPTH(4), .RESP_TIMEOUT(15)) u_dut4 (
        .clk(clk), .reset(rst4), .piece_valid(piece_valid), .piece_type(piece_type),
        .piece_ready(ready4), .req_to_client(req4), .cur_block(cur4),
        .row1_info(r1_4), .row2_info(r2_4), .resp_from_client(resp),
        .opt_col(opt_col), .opt_rotation(opt_rot), .game_over(go4),
        .lines_total(lines4), .pieces_placed(pieces4), .timeout_cnt(tmo4), .bad_resp(bad4)
    );

    // The instance not under test is held in reset, so the inputs can be shared.
    logic        ready_m, req_m, go_m, bad_m;
    logic [3:0]  cur_m;
    logic [9:0]  row1_m, row2_m;
    logic [15:0] lines_m, pieces_m;
    logic [7:0]  tmo_m;

    assign ready_m  = sel4 ? ready4  : ready8;
    assign req_m    = sel4 ? req4    : req8;
    assign go_m     = sel4 ? go4     : go8;
    assign bad_m    = sel4 ? bad4    : bad8;
    assign cur_m    = sel4 ? cur4    : cur8;
    assign row1_m   = sel4 ? r1_4    : r1_8;
    assign row2_m   = sel4 ? r2_4    : r2_8;
    assign lines_m  = sel4 ? lines4  : lines8;
    assign pieces_m = sel4 ? pieces4 : pieces8;
    assign tmo_m    = sel4 ? tmo4    : tmo8;

    always @(negedge clk) begin
        if (req_m) n_req <= n_req + 1;
        if (bad_m) n_badresp <= n_badresp + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready_m && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ready_m), 32'd1);
    endtask

    // Offer one piece; a registered client answers two cycles after acceptance.
    task automatic place(input logic [3:0] t, input logic [3:0] col, input logic [1:0] rot,
                         input bit respond, input bit wait_done);
        wait_ready("ready_pre");
        piece_valid = 1'b1;
        piece_type  = t;
        @(negedge clk);
        piece_valid = 1'b0;
        check("req_on", 32'(req_m), 32'd1);
        check("cur_block", 32'(cur_m), 32'(t));
        if (respond) begin
            @(negedge clk);
            resp    = 1'b1;
            opt_col = col;
            opt_rot = rot;
            @(negedge clk);
            resp    = 1'b0;
            check("req_off", 32'(req_m), 32'd0);
        end
        if (wait_done) wait_ready("ready_post");
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"},  32'(ready_m),  32'd0);
        check({tag, "_req"},    32'(req_m),    32'd0);
        check({tag, "_row1"},   32'(row1_m),   32'd0);
        check({tag, "_row2"},   32'(row2_m),   32'd0);
        check({tag, "_lines"},  32'(lines_m),  32'd0);
        check({tag, "_pieces"}, 32'(pieces_m), 32'd0);
        check({tag, "_tmo"},    32'(tmo_m),    32'd0);
        check({tag, "_go"},     32'(go_m),     32'd0);
        check({tag, "_bad"},    32'(bad_m),    32'd0);
        check({tag, "_cur"},    32'(cur_m),    32'd0);
    endtask

    initial begin
        int r0, b0, cnt;
        rst8 = 1'b1; rst4 = 1'b1; sel4 = 1'b0;
        piece_valid = 1'b0; piece_type = 4'd0; resp = 1'b0; opt_col = 4'd0; opt_rot = 2'd0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst8 = 1'b0;
        @(negedge clk);
        check("ready_rise", 32'(ready_m), 32'd1);

        // Single horizontal I at col 0
        place(4'd0, 4'd0, 2'd0, 1'b1, 1'b1);
        check("t1_row1", 32'(row1_m), 32'b1111000000);
        check("t1_row2", 32'(row2_m), 32'd0);
        check("t1_pieces", 32'(pieces_m), 32'd1);

        // Fill and clear the bottom row
        place(4'd0, 4'd4, 2'd0, 1'b1, 1'b1);
        check("t2_row1_mid", 32'(row1_m), 32'b1111111100);
        place(4'd3, 4'd8, 2'd0, 1'b1, 1'b1);
        check("t2_lines", 32'(lines_m), 32'd1);
        check("t2_row1", 32'(row1_m), 32'b0000000011);
        check("t2_row2", 32'(row2_m), 32'd0);
        check("t2_pieces", 32'(pieces_m), 32'd3);
        check("t2_no_bad", 32'(n_badresp), 32'd0);

        // O at col 9 clamps to col 8 and stacks on the leftover O half
        b0 = n_badresp;
        place(4'd5, 4'd9, 2'd2, 1'b1, 1'b1);
        check("t3_bad_pulses", 32'(n_badresp - b0), 32'd1);
        check("t3_row1", 32'(row1_m), 32'b0000000011);
        check("t3_row2", 32'(row2_m), 32'b0000000011);
        check("t3_pieces", 32'(pieces_m), 32'd4);

        // Silent client: 15 request cycles, then col 0 rot 0
        r0 = n_req;
        place(4'd0, 4'd0, 2'd0, 1'b0, 1'b1);
        check("t4_req_cycles", 32'(n_req - r0), 32'd15);
        check("t4_tmo", 32'(tmo_m), 32'd1);
        check("t4_row1", 32'(row1_m), 32'b1111000011);
        check("t4_row2", 32'(row2_m), 32'b0000000011);
        check("t4_pieces", 32'(pieces_m), 32'd5);

        // Reset while the piece is dropping
        place(4'd0, 4'd4, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        check_zero("t5");
        rst8 = 1'b0;
        @(negedge clk);
        check("t5_ready", 32'(ready_m), 32'd1);
        place(4'd0, 4'd6, 2'd0, 1'b1, 1'b1);
        check("t5_row1", 32'(row1_m), 32'b0000001111);
        check("t5_pieces", 32'(pieces_m), 32'd1);

        // DEPTH 4: the second vertical I collides at the top
        rst8 = 1'b1;
        sel4 = 1'b1;
        rst4 = 1'b0;
        @(negedge clk);
        check("t6_ready", 32'(ready_m), 32'd1);
        place(4'd0, 4'd0, 2'd1, 1'b1, 1'b1);
        check("t6_row1", 32'(row1_m), 32'b1000000000);
        check("t6_row2", 32'(row2_m), 32'b1000000000);
        check("t6_go0", 32'(go_m), 32'd0);
        place(4'd0, 4'd0, 2'd1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("t6_go", 32'(go_m), 32'd1);
        check("t6_row1_kept", 32'(row1_m), 32'b1000000000);
        check("t6_row2_kept", 32'(row2_m), 32'b1000000000);
        check("t6_pieces", 32'(pieces_m), 32'd1);
        piece_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready_m || req_m) cnt++;
        end
        piece_valid = 1'b0;
        check("t6_stuck", 32'(cnt), 32'd0);
        check("t6_go_sticky", 32'(go_m), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tetris_host.md
# tetris_host

Game-side initiator of the placement request/response protocol. Accepts a stream of pieces, presents the current piece and the bottom two board rows to the placement client, and collects the client's column/rotation answer. It then drops the piece by gravity into an internal DEPTH×10 board, clears full rows, and tracks statistics. It sits between the piece source and the placement client and owns the board state.

## Interface
- DEPTH, 8: board height in rows (min 4); row 0 is the bottom.
- RESP_TIMEOUT, 15: cycles to wait for resp_from_client before defaulting.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- piece_valid  in  1  piece source has a piece
- piece_type  in  4  0 = I piece, any other value = O piece
- piece_ready  out  1  host accepts a piece this cycle
- req_to_client  out  1  placement request
- cur_block  out  4  latched piece_type of the piece being placed
- row1_info  out  10  board row 0
- row2_info  out  10  board row 1
- resp_from_client  in  1  client answer valid
- opt_col  in  4  leftmost column of the piece
- opt_rotation  in  2  rotation
- game_over  out  1  sticky; piece could not enter the board
- lines_total  out  16  rows cleared, saturating at 16'hFFFF
- pieces_placed  out  16  pieces landed, wraps
- timeout_cnt  out  8  responses timed out, saturating
- bad_resp  out  1  one-cycle pulse: opt_col was clamped

## Operation
- Column k maps to row bit [9-k]. A piece occupies columns opt_col .. opt_col+W-1.
- Shapes:
  - O: W=2, H=2, all rotations.
  - I with rotation 0/2: W=4, H=1.
  - I with rotation 1/3: W=1, H=4.
- FSM states: IDLE, REQ, DROP, LAND, CLEAR, OVER.
- IDLE: piece_ready = 1 iff resp_from_client==0 and not game_over. On valid&&ready, latch cur_block and go to REQ.
- REQ: req_to_client = 1.
  - On resp_from_client = 1: latch opt_col/opt_rotation, go to DROP.
  - If RESP_TIMEOUT cycles elapse without a response: use col 0, rotation 0, increment timeout_cnt, go to DROP.
- Column clamp: if opt_col + W > 10, use 10-W and pulse bad_resp for one cycle.
- DROP: the candidate row r starts at DEPTH-H and the first DROP cycle tests r.
  - Collision at r = DEPTH-H: set game_over and go to OVER. The board is unchanged.
  - Otherwise, on each later cycle: if r > 0 and r-1 is collision-free, set r = r-1. Else go to LAND.
- LAND: OR the piece mask into rows r .. r+H-1, increment pieces_placed, set scan index j = 0, go to CLEAR.
- CLEAR, one step per cycle:
  - If row j == 10'h3FF: rows j+1..DEPTH-1 shift down by one, the top row becomes 0, lines_total increments, and j is unchanged.
  - Otherwise j increments.
  - When j == DEPTH, go to IDLE.
- OVER: absorbing. piece_ready = 0, req_to_client = 0, until reset.
- row1_info and row2_info reflect the registered board continuously, and are stable while req_to_client is high.

## Timing
- All outputs are registered. Reset value is 0 for every output and for the whole board; the FSM resets to IDLE.
- piece_ready first rises in the cycle after reset deasserts.
- Handshake, with a piece accepted at edge T:
  - req_to_client = 1 from T+1 and held until resp_from_client is sampled high at edge R.
  - req_to_client = 0 from R+1.
  - A registered client gives R = T+2 at the earliest.
- The host never reasserts req_to_client while resp_from_client is high.
- Timeout: counted from the first REQ cycle. The exit happens on the edge after RESP_TIMEOUT REQ cycles. A response arriving on that same edge wins over the timeout.
- Latency from acceptance to next piece_ready is 2 + response wait + (DEPTH-H-r_final+1) DROP cycles + 1 LAND + CLEAR cycles. CLEAR takes DEPTH plus the number of cleared rows.
- Reset asserted in any state, including mid-DROP or CLEAR: next cycle the FSM is in IDLE and the board, counters and game_over are all 0.

## Test plan
- Reset, then an I piece with the client answering col 0 rot 0 → row1_info = 10'b1111000000, pieces_placed = 1, row2_info = 0.
- Pieces I col 0, I col 4, O col 8 (rot 0) on an empty board → bottom row fills and is cleared. Then lines_total = 1, row1_info = 10'b0000000011, row2_info = 0.
- O piece, client answers col 9 → bad_resp pulses once, the piece lands at col 8, and row1_info = row2_info = 10'b0000000011.
- Client never responds, RESP_TIMEOUT = 15 → req_to_client is high for exactly 15 cycles, timeout_cnt = 1, and the piece lands at col 0.
- DEPTH = 4, feed vertical I pieces (rot 1) at col 0 repeatedly → the second piece collides at the top. game_over = 1, piece_ready stays 0, and the board is unchanged.
- Assert reset during DROP → all outputs 0 the next cycle, and piece_ready = 1 one cycle after reset is released.
